psum_accum: RTL
===============

# psum_accum

Channel-accumulation and requantization stage sitting directly downstream of the partial-sum delay line in the conv datapath. It consumes one signed partial sum per accepted cycle and accumulates each output pixel of a row across `CH_NB` input-channel passes in an internal row buffer, adding bias on the first pass. On the last pass it shifts, optionally applies ReLU, saturates to `OUT_BW`, and emits the pixel through a 2-entry output FIFO with valid/ready backpressure.

## Interface
- `SUM_BW`, 16: width of incoming signed partial sum and bias.
- `ACC_BW`, 20: width of signed accumulator entries.
- `OUT_BW`, 8: width of signed output pixel.
- `ROW_NB`, 27: pixels per row, which is the accumulator buffer depth.
- `CH_NB`, 3: input-channel passes per row; minimum 1.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_clear` in 1: synchronous clear of counters and FIFO.
- `i_valid` in 1: `i_psum` valid.
- `i_ready` out 1: stage can accept `i_psum`.
- `i_psum` in `SUM_BW` signed: partial sum from delay line.
- `i_bias` in `SUM_BW` signed: bias; held stable per row.
- `i_shift` in 5: arithmetic right shift amount; held stable per row.
- `o_valid` out 1: output FIFO head valid.
- `o_ready` in 1: consumer accepts head.
- `o_data` out `OUT_BW` signed: requantized pixel.
- `o_last` out 1: head is the last pixel of a row.

## Operation
- Accept occurs when `i_valid && i_ready`. Only accepts advance state.
- Counters:
  - `pix_cnt` runs 0..`ROW_NB`-1.
  - `ch_cnt` runs 0..`CH_NB`-1.
  - On accept, `pix_cnt` increments. On wrap, `pix_cnt` returns to 0 and `ch_cnt` increments. On `ch_cnt` wrap, the next row begins.
- Accumulate, with `sum` computed as follows:
  - If `ch_cnt`==0: `sum` = sext(`i_psum`) + sext(`i_bias`).
  - Otherwise: `sum` = `acc[pix_cnt]` + sext(`i_psum`).
  - Arithmetic is modulo 2^`ACC_BW` and never saturates.
  - `acc[pix_cnt]` <= `sum` on accept when `ch_cnt` != `CH_NB`-1.
- Last pass (`ch_cnt`==`CH_NB`-1), requantize `sum` combinationally:
  - `sh` = `sum` >>> `i_shift`.
  - Apply ReLU when `PSUM_ACCUM_RELU_EN` is defined (see Configuration).
  - Saturate to [-2^(`OUT_BW`-1), 2^(`OUT_BW`-1)-1].
  - Push {data, last=(`pix_cnt`==`ROW_NB`-1)} into the FIFO on the accept edge.
- With `CH_NB`==1, every accept is a last pass: `sum` = psum + bias, and the buffer is unused.
- Ready rule: `i_ready` = (`ch_cnt` != `CH_NB`-1) || (`fifo_cnt` < 2) || `o_ready`. This is a combinational path from `o_ready`.
- FIFO:
  - 2 entries, in order.
  - A simultaneous push and pop when full is legal and keeps the count at 2.
  - A pop when empty is ignored.
- `i_clear`:
  - Zeroes `pix_cnt`, `ch_cnt` and `fifo_cnt`, and drops `o_valid` on the next edge.
  - Accumulator contents are don't-care, because the next pass 0 overwrites them.
  - If `i_clear` is high together with an accept, the accept is discarded and clear wins.
- Illegal stimulus: changing `i_bias` or `i_shift` mid-row gives undefined output for that row and needs no checking.

## Timing
- Reset values:
  - `o_valid`=0, `o_data`=0, `o_last`=0.
  - Counters and `fifo_cnt` = 0.
  - `acc` entries = 0.
  - `i_ready`=1.
- Latency: an accept at edge N on the last pass gives `o_valid`=1 with that pixel after edge N, provided the FIFO was empty or popping.
- Reset mid-row aborts the row; the first accept after reset is pixel 0, pass 0.
- Throughput: 1 pixel per cycle sustained when `o_ready`=1.
- Stall behaviour: `i_ready` deasserts only during the last pass. Passes 0..`CH_NB`-2 never stall.

## Configuration
- Macro: `PSUM_ACCUM_RELU_EN`.
  - Defined: a negative `sh` becomes 0 before saturation, so `o_data` ≥ 0.
  - Undefined: signed saturation only, so negative outputs pass through.

## Test plan
- Bias and accumulation: `CH_NB`=3, pixel 0 psums 10,20,30, bias 5, shift 0 -> `o_data`=65 one cycle after the third-pass accept, `o_last`=0. Pixel 26 -> `o_last`=1.
- Saturation: psums 400,300,300, bias 0, shift 2 -> 1000>>>2=250 -> `o_data`=127. Psums -400,-300,-300 without the macro -> -128.
- ReLU: psums -10,-10,-20, bias 0 -> `o_data`=0 with `PSUM_ACCUM_RELU_EN`, -40 without.
- Backpressure: hold `o_ready`=0 during the last pass -> two pixels are buffered, then `i_ready`=0. Raise `o_ready` -> pixels drain in order with none lost or duplicated, and `i_ready` rises the same cycle.
- Continuity: stream 2 full rows back-to-back with `i_valid`=1 and `o_ready`=1 -> 54 outputs, `o_last` on outputs 27 and 54, with no bubbles on the input side.
- Reset and clear: assert `rst_n`=0 mid pass 1 -> all outputs 0. Then a fresh row gives correct sums. Pulse `i_clear` with the FIFO full -> `o_valid`=0 on the next cycle and counters restart at 0.

Source files
------------

// File: rtl/psum_accum_if.sv
// Handshake bundle for psum_accum: upstream partial-sum channel plus downstream pixel channel.
// master = producer/consumer side (bench or neighbours), slave = the accumulator stage.
interface psum_accum_if #(
   parameter int SUM_BW = 16,
   parameter int OUT_BW = 8
);
   logic                     i_valid;
   logic                     i_ready;
   logic signed [SUM_BW-1:0] i_psum;
   logic signed [SUM_BW-1:0] i_bias;
   logic [4:0]               i_shift;
   logic                     o_valid;
   logic                     o_ready;
   logic signed [OUT_BW-1:0] o_data;
   logic                     o_last;

   modport master (
      output i_valid, i_psum, i_bias, i_shift, o_ready,
      input  i_ready, o_valid, o_data, o_last
   );

   modport slave (
      input  i_valid, i_psum, i_bias, i_shift, o_ready,
      output i_ready, o_valid, o_data, o_last
   );
endinterface

// File: rtl/psum_accum.sv
// Channel accumulation over CH_NB passes per row, bias on pass 0, shift/saturate on the last pass.
// Optional macro PSUM_ACCUM_RELU_EN clamps negative shifted sums to zero before saturation.
module psum_accum #(
   parameter int SUM_BW = 16,
   parameter int ACC_BW = 20,
   parameter int OUT_BW = 8,
   parameter int ROW_NB = 27,
   parameter int CH_NB  = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clear,
   psum_accum_if.slave  bus
);
   localparam int PIX_W = (ROW_NB > 1) ? $clog2(ROW_NB) : 1;
   localparam int CH_W  = (CH_NB  > 1) ? $clog2(CH_NB)  : 1;
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(ROW_NB - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH_NB - 1);
   localparam logic signed [ACC_BW-1:0] SAT_MAX = ACC_BW'(2**(OUT_BW-1) - 1);
   localparam logic signed [ACC_BW-1:0] SAT_MIN = ACC_BW'(-(2**(OUT_BW-1)));

   logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [CH_W-1:0]  ch_cnt_q,  ch_cnt_d;
   logic [1:0]       fifo_cnt_q, fifo_cnt_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;

   logic signed [ACC_BW-1:0] acc_q [ROW_NB];
   logic signed [OUT_BW-1:0] fifo_data_q [2];
   logic                     fifo_last_q [2];

   logic                     last_pass;
   logic                     last_pix;
   logic                     accept;
   logic                     push;
   logic                     pop;
   logic                     acc_we;
   logic signed [ACC_BW-1:0] psum_ext;
   logic signed [ACC_BW-1:0] bias_ext;
   logic signed [ACC_BW-1:0] acc_rd;
   logic signed [ACC_BW-1:0] sum;
   logic signed [ACC_BW-1:0] sh;
   logic signed [ACC_BW-1:0] relu_val;
   logic signed [OUT_BW-1:0] q_data;

   assign last_pass = (ch_cnt_q == CH_LAST);
   assign last_pix  = (pix_cnt_q == PIX_LAST);

   // The o_ready term lets a full FIFO accept a push in the same cycle it pops.
   assign bus.i_ready = !last_pass || (fifo_cnt_q != 2'd2) || bus.o_ready;

   assign accept = bus.i_valid && bus.i_ready && !i_clear;
   assign push   = accept && last_pass;
   assign pop    = (fifo_cnt_q != 2'd0) && bus.o_ready && !i_clear;
   assign acc_we = accept && !last_pass;

   assign psum_ext = ACC_BW'(bus.i_psum);
   assign bias_ext = ACC_BW'(bus.i_bias);
   assign acc_rd   = acc_q[pix_cnt_q];
   assign sum      = (ch_cnt_q == '0) ? (psum_ext + bias_ext) : (acc_rd + psum_ext);
   assign sh       = sum >>> bus.i_shift;

   always_comb begin
      relu_val = sh;
`ifdef PSUM_ACCUM_RELU_EN
      if (sh < 0) begin
         relu_val = '0;
      end
`else
      relu_val = sh;
`endif
      if (relu_val > SAT_MAX) begin
         q_data = SAT_MAX[OUT_BW-1:0];
      end else if (relu_val < SAT_MIN) begin
         q_data = SAT_MIN[OUT_BW-1:0];
      end else begin
         q_data = relu_val[OUT_BW-1:0];
      end
   end

   always_comb begin
      pix_cnt_d = pix_cnt_q;
      ch_cnt_d  = ch_cnt_q;
      if (i_clear) begin
         pix_cnt_d = '0;
         ch_cnt_d  = '0;
      end else if (accept) begin
         if (last_pix) begin
            pix_cnt_d = '0;
            ch_cnt_d  = last_pass ? '0 : ch_cnt_q + 1'b1;
         end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (i_clear) begin
         fifo_cnt_d = 2'd0;
         wr_ptr_d   = 1'b0;
         rd_ptr_d   = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt_q  <= '0;
         ch_cnt_q   <= '0;
         fifo_cnt_q <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
      end else begin
         pix_cnt_q  <= pix_cnt_d;
         ch_cnt_q   <= ch_cnt_d;
         fifo_cnt_q <= fifo_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Row buffer: read is combinational because pass 1..N-1 add into the same pixel this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ROW_NB; i++) begin
            acc_q[i] <= '0;
         end
      end else if (acc_we) begin
         acc_q[pix_cnt_q] <= sum;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
      end else if (push) begin
         fifo_data_q[wr_ptr_q] <= q_data;
         fifo_last_q[wr_ptr_q] <= last_pix;
      end
   end

   assign bus.o_valid = (fifo_cnt_q != 2'd0);
   assign bus.o_data  = fifo_data_q[rd_ptr_q];
   assign bus.o_last  = fifo_last_q[rd_ptr_q];

endmodule
